// File: rtl/button_debounce_if.sv
// Button bus between the raw pins, the debouncer and its consumers (PIO in_port, fabric).
interface button_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] button_in;
    logic [WIDTH-1:0] button_out;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (
        output button_in,
        input  button_out, press_pulse, release_pulse
    );

    modport slave (
        input  button_in,
        output button_out, press_pulse, release_pulse
    );
endinterface

// File: rtl/button_debounce.sv
// Per-channel 2-flop synchroniser + STABLE/CHECK debounce FSM with registered press/release strobes.
// Optional auto-repeat of press_pulse while held: define BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_lvl,
    output logic level,
    output logic press,
    output logic rel_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {STABLE, CHECK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_run;
    logic          level_nx, press_nx, rel_nx, rep_due;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STABLE;
            cnt       <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            level     <= level_nx;
            press     <= press_nx;
            rel_pulse <= rel_nx;
        end
    end

    // cnt_run includes the current mismatched sample, so the level flips on the
    // DEBOUNCE_CYCLES-th consecutive mismatch (edge DEBOUNCE_CYCLES+1 after sync1 capture).
    always_comb begin
        cnt_run  = (state == CHECK) ? cnt + CW'(1) : CW'(1);
        state_nx = STABLE;
        cnt_nx   = '0;
        level_nx = level;
        if (sync_lvl != level) begin
            if (cnt_run >= CNT_MAX) begin
                level_nx = ~level;
            end else begin
                state_nx = CHECK;
                cnt_nx   = cnt_run;
            end
        end
    end

    always_comb begin
        press_nx = (level_nx & ~level) | rep_due;
        rel_nx   = ~level_nx & level;
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    logic [31:0] hold, hold_nx, phase, phase_nx;
    logic [32:0] hold_inc;

    // hold = cycles since level rose; phase tracks position inside the repeat period.
    always_comb begin
        hold_inc = {1'b0, hold} + 33'd1;
        rep_due  = 1'b0;
        hold_nx  = '0;
        phase_nx = '0;
        if (level && level_nx) begin
            rep_due = (hold_inc == 33'(REPEAT_DELAY)) ||
                      ((hold_inc > 33'(REPEAT_DELAY)) && (phase == 32'(REPEAT_PERIOD - 1)));
            hold_nx = hold_inc[32] ? hold : hold_inc[31:0];
            if (rep_due)
                phase_nx = '0;
            else if (hold_inc > 33'(REPEAT_DELAY))
                phase_nx = phase + 32'd1;
            else
                phase_nx = phase;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold  <= '0;
            phase <= '0;
        end else begin
            hold  <= hold_nx;
            phase <= phase_nx;
        end
    end
`else
    assign rep_due = 1'b0;
`endif
endmodule

module button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic               clk,
    input logic               reset,
    button_debounce_if.slave  btn
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range 1..2^20");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [WIDTH-1:0] raw, sync1, sync2, level, press, rel;

    assign raw = btn.button_in ^ {WIDTH{ACTIVE_LOW != 0}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        button_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .sync_lvl  (sync2[g]),
            .level     (level[g]),
            .press     (press[g]),
            .rel_pulse (rel[g])
        );
    end

    assign btn.button_out    = level;
    assign btn.press_pulse   = press;
    assign btn.release_pulse = rel;
endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: vector table, hand-written corner sequences, randomized bounce vs window model.
module tb_button_debounce;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_debounce_if #(.WIDTH(W)) bif();

    button_debounce #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: a level flips when the last D synchronised samples all disagree with it.
    logic [W-1:0] m_out, m_press, m_rel;
    logic [W-1:0] cap [D+2];
    int           hold_m [W];

    task automatic model_reset();
        m_out = '0; m_press = '0; m_rel = '0;
        for (int k = 0; k < D + 2; k++) cap[k] = '0;
        for (int c = 0; c < W; c++) hold_m[c] = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] pins);
        logic all_diff, nv, ov;
        for (int k = D + 1; k > 0; k--) cap[k] = cap[k-1];
        cap[0] = ~pins;
        for (int c = 0; c < W; c++) begin
            ov = m_out[c];
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (cap[k][c] == ov) all_diff = 1'b0;
            nv = all_diff ? ~ov : ov;
            m_press[c] = nv & ~ov;
            m_rel[c]   = ~nv & ov;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            if (nv && ov) begin
                hold_m[c]++;
                if (hold_m[c] >= RD && ((hold_m[c] - RD) % RP) == 0) m_press[c] = 1'b1;
            end else begin
                hold_m[c] = 0;
            end
`endif
            m_out[c] = nv;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic r, input logic [W-1:0] b);
        reset = r;
        bif.button_in = b;
        if (r) model_reset();
        @(posedge clk);
        if (!r) model_edge(b);
        #2;
        check("button_out", bif.button_out, m_out);
        check("press_pulse", bif.press_pulse, m_press);
        check("release_pulse", bif.release_pulse, m_rel);
        @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] out;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } vec_t;

    vec_t         tv [24];
    logic [W-1:0] lvl;
    int           cnt_p, at_p;
    int           exp_t [$];
    int           got_t [$];

    initial begin
        // ch0 press from edge 0, then release, then a 3-cycle glitch on ch1
        for (int i = 0; i < 5; i++)   tv[i] = '{4'hE, 4'h0, 4'h0, 4'h0};
        tv[5] = '{4'hE, 4'h1, 4'h1, 4'h0};
        tv[6] = '{4'hE, 4'h1, 4'h0, 4'h0};
        for (int i = 7; i < 12; i++)  tv[i] = '{4'hF, 4'h1, 4'h0, 4'h0};
        tv[12] = '{4'hF, 4'h0, 4'h0, 4'h1};
        tv[13] = '{4'hF, 4'h0, 4'h0, 4'h0};
        for (int i = 14; i < 17; i++) tv[i] = '{4'hD, 4'h0, 4'h0, 4'h0};
        for (int i = 17; i < 24; i++) tv[i] = '{4'hF, 4'h0, 4'h0, 4'h0};

        reset = 1'b1;
        bif.button_in = 4'hF;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset button_out", bif.button_out, 4'h0);
        check("reset press", bif.press_pulse, 4'h0);
        check("reset release", bif.release_pulse, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'hF);

        for (int i = 0; i < 24; i++) begin
            step(1'b0, tv[i].btn);
            check($sformatf("tv%0d out", i), bif.button_out, tv[i].out);
            check($sformatf("tv%0d press", i), bif.press_pulse, tv[i].press);
            check($sformatf("tv%0d rel", i), bif.release_pulse, tv[i].rel);
        end

        // Bounce on ch2: L,H,L,L,H then steady L; last H->L is step 5
        begin
            logic [W-1:0] pat [15];
            pat[0] = 4'hB; pat[1] = 4'hF; pat[2] = 4'hB; pat[3] = 4'hB; pat[4] = 4'hF;
            for (int i = 5; i < 15; i++) pat[i] = 4'hB;
            cnt_p = 0; at_p = -1;
            for (int i = 0; i < 15; i++) begin
                step(1'b0, pat[i]);
                if (bif.press_pulse[2]) begin cnt_p++; at_p = i; end
            end
            check_int("bounce press count", cnt_p, 1);
            check_int("bounce press step", at_p, 10);
            for (int i = 0; i < 8; i++) step(1'b0, 4'hF);
        end

        // All four pressed together for 20 cycles; ch0 press times recorded for repeat
        got_t.delete();
        for (int i = 0; i < 28; i++) begin
            step(1'b0, (i < 20) ? 4'h0 : 4'hF);
            if (bif.press_pulse[0]) got_t.push_back(i - 5);
            if (i == 5) begin
                check("all out", bif.button_out, 4'hF);
                check("all press", bif.press_pulse, 4'hF);
            end
            if (i == 25) begin
                check("all released out", bif.button_out, 4'h0);
                check("all release", bif.release_pulse, 4'hF);
            end
        end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        exp_t = '{0, 10, 13, 16, 19};
`else
        exp_t = '{0};
`endif
        check_int("press count ch0", got_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < got_t.size(); i++)
            check_int($sformatf("press time %0d", i), got_t[i], exp_t[i]);

        // ch3 held through a 2-cycle reset
        for (int i = 0; i < 8; i++) step(1'b0, 4'h7);
        reset = 1'b1;
        #1;
        check("async reset out", bif.button_out, 4'h0);
        model_reset();
        @(negedge clk);
        step(1'b1, 4'h7);
        step(1'b1, 4'h7);
        cnt_p = 0; at_p = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h7);
            if (bif.press_pulse[3]) begin cnt_p++; at_p = i; end
        end
        check_int("post-reset press count", cnt_p, 1);
        check_int("post-reset press edge", at_p, D + 1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'hF);

        // Randomized bouncing, fast then slow, with occasional resets
        lvl = 4'hF;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, (i < 1000) ? 5 : 39) == 0) lvl[c] = ~lvl[c];
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
